// File: rtl/data_delivery_sequencer_if.sv
// rtl/data_delivery_sequencer_if.sv - operand buffer read port and delivery-subsystem lane bus
// The sequencer drives through master; the buffer/delivery side connects through slave.
interface data_delivery_sequencer_if #(
   parameter int W  = 32,
   parameter int AW = 10
);
   logic          buf_re;
   logic [AW-1:0] buf_addr;
   logic [W-1:0]  buf_rdata;
   logic [W-1:0]  dd_data;
   logic          dd_select;
   logic [2:0]    dd_rptr;
   logic          dd_rptr_ack;
   logic          dd_n4_full;
   logic          dd_uni_read;

   modport master (
      output buf_re, buf_addr, dd_data, dd_select, dd_rptr,
      input  buf_rdata, dd_rptr_ack, dd_n4_full, dd_uni_read
   );

   modport slave (
      input  buf_re, buf_addr, dd_data, dd_select, dd_rptr,
      output buf_rdata, dd_rptr_ack, dd_n4_full, dd_uni_read
   );
endinterface

// File: rtl/data_delivery_sequencer.sv
// rtl/data_delivery_sequencer.sv - feeds 8 lanes x WPL words per tile from the operand buffer
// Per tile: fetch/capture each lane, wait for lane ack, then N4-full and unified-read handshakes.
module data_delivery_sequencer #(
   parameter int W       = 32,
   parameter int AW      = 10,
   parameter int WPL     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [AW-1:0]             base_addr,
   input  logic [7:0]                num_tiles,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [7:0]                tiles_done,
   data_delivery_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, FETCH, CAPTURE, ACK_WAIT, FULL_WAIT, READ_WAIT, FINISH
   } state_t;

   state_t        state, state_nx;
   logic [AW-1:0] addr;
   logic [7:0]    ntiles;
   logic [3:0]    wcnt;
   logic [15:0]   tcnt;
   logic [W-1:0]  data_q;
   logic          select_q;
   logic [2:0]    rptr_q;
   logic          in_wait;
   logic          timed_out;
   logic          fault;
   logic          last_word;

   assign bus.buf_re    = (state == FETCH);
   assign bus.buf_addr  = addr;
   assign bus.dd_data   = data_q;
   assign bus.dd_select = select_q;
   assign bus.dd_rptr   = rptr_q;

   always_comb begin
      in_wait   = (state == ACK_WAIT) || (state == FULL_WAIT) || (state == READ_WAIT);
      timed_out = in_wait && (tcnt == 16'(TIMEOUT - 1));
      last_word = (wcnt >= 4'(WPL - 1));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Handshake events take priority over a timeout expiring in the same cycle.
   always_comb begin
      state_nx = state;
      fault    = 1'b0;
      case (state)
         IDLE:      if (start) state_nx = (num_tiles == 8'd0) ? FINISH : FETCH;
         FETCH:     state_nx = CAPTURE;
         CAPTURE:   state_nx = last_word ? ACK_WAIT : FETCH;
         ACK_WAIT: begin
            if (bus.dd_rptr_ack)  state_nx = (rptr_q == 3'd7) ? FULL_WAIT : FETCH;
            else if (timed_out) begin
               state_nx = FINISH;
               fault    = 1'b1;
            end
         end
         FULL_WAIT: begin
            if (bus.dd_n4_full)   state_nx = READ_WAIT;
            else if (timed_out) begin
               state_nx = FINISH;
               fault    = 1'b1;
            end
         end
         READ_WAIT: begin
            if (bus.dd_uni_read)  state_nx = ((tiles_done + 8'd1) == ntiles) ? FINISH : FETCH;
            else if (timed_out) begin
               state_nx = FINISH;
               fault    = 1'b1;
            end
         end
         FINISH:    state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         tiles_done <= 8'd0;
         addr       <= '0;
         ntiles     <= 8'd0;
         wcnt       <= 4'd0;
         tcnt       <= 16'd0;
         data_q     <= '0;
         select_q   <= 1'b0;
         rptr_q     <= 3'd0;
      end else begin
         done     <= 1'b0;
         select_q <= (state == CAPTURE);
         if (state_nx != state) tcnt <= 16'd0;
         else if (in_wait)      tcnt <= tcnt + 16'd1;
         case (state)
            IDLE: if (start) begin
               addr       <= base_addr;
               ntiles     <= num_tiles;
               error      <= 1'b0;
               tiles_done <= 8'd0;
               busy       <= 1'b1;
               rptr_q     <= 3'd0;
               wcnt       <= 4'd0;
            end
            FETCH:   addr <= addr + 1'b1;
            CAPTURE: begin
               data_q <= bus.buf_rdata;
               wcnt   <= last_word ? 4'd0 : wcnt + 4'd1;
            end
            ACK_WAIT: if (bus.dd_rptr_ack && rptr_q != 3'd7) rptr_q <= rptr_q + 3'd1;
            READ_WAIT: if (bus.dd_uni_read) begin
               tiles_done <= tiles_done + 8'd1;
               rptr_q     <= 3'd0;
            end
            FINISH: begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
         if (fault) error <= 1'b1;
      end
   end
endmodule
